// File: rtl/jtexterm_sub_comm.sv
// Sub-CPU side of the main/sub shared comm RAM: decodes the sub bus window,
// issues one port-1 RAM transaction per CPU cycle and holds WAIT until it completes.
module jtexterm_sub_comm #(
    parameter int          AW      = 13,
    parameter logic [15:0] BASE    = 16'hC000,
    parameter int          MAXWAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          snd_rstn,
    input  logic [15:0]   sub_A,
    input  logic          sub_mreq_n,
    input  logic          sub_rd_n,
    input  logic          sub_wr_n,
    input  logic [7:0]    sub_cpu_dout,
    output logic [7:0]    sub_cpu_din,
    output logic          sub_wait_n,
    output logic          comm_cs,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_dout,
    output logic          ram_we,
    input  logic [7:0]    ram_din,
    input  logic [AW-1:0] main_addr,
    input  logic          main_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STALL,
        S_ACCESS,
        S_LATCH,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          done_q, done_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]    ram_dout_q, ram_dout_d;
    logic [7:0]    din_q, din_d;

    logic hit, strobe, is_wr, conflict;

    assign hit      = !sub_mreq_n && (sub_A[15:AW] == BASE[15:AW]);
    assign strobe   = !sub_rd_n || !sub_wr_n;
    assign is_wr    = !sub_wr_n;
    assign conflict = main_we && (main_addr == sub_A[AW-1:0]);

    assign comm_cs     = hit;
    assign sub_wait_n  = !(hit && strobe && !done_q);
    assign sub_cpu_din = din_q;
    assign ram_addr    = ram_addr_q;
    assign ram_dout    = ram_dout_q;
    assign ram_we      = ram_we_q;

    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_dout_d = ram_dout_q;
        din_d      = din_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (hit && strobe && !done_q) begin
                    if (conflict) begin
                        state_d = S_STALL;
                    end else begin
                        state_d    = S_ACCESS;
                        ram_addr_d = sub_A[AW-1:0];
                        wr_d       = is_wr;
                        ram_we_d   = is_wr;
                        if (is_wr) ram_dout_d = sub_cpu_dout;
                    end
                end
            end
            S_STALL: begin
                cnt_d = cnt_q + 4'd1;
                // Forcing after MAXWAIT clk keeps the sub CPU from starving.
                if (!conflict || cnt_q == 4'(MAXWAIT - 1)) begin
                    state_d    = S_ACCESS;
                    ram_addr_d = sub_A[AW-1:0];
                    wr_d       = is_wr && hit;
                    ram_we_d   = is_wr && hit;
                    if (is_wr && hit) ram_dout_d = sub_cpu_dout;
                end
            end
            S_ACCESS: begin
                if (wr_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                din_d   = ram_din;
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                if (!strobe || !hit) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= 8'h00;
            din_q      <= 8'hFF;
        end else if (!snd_rstn) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= 8'h00;
            din_q      <= 8'hFF;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            din_q      <= din_d;
        end
    end

endmodule

// File: tb/tb_jtexterm_sub_comm.sv
// Bench for jtexterm_sub_comm: a port-1 RAM stub plus a transaction-level
// model (wait length, write pulses, read data) checked over directed and random accesses.
module tb_jtexterm_sub_comm;

    localparam int AW      = 13;
    localparam int MAXWAIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          snd_rstn;
    logic [15:0]   sub_A;
    logic          sub_mreq_n;
    logic          sub_rd_n;
    logic          sub_wr_n;
    logic [7:0]    sub_cpu_dout;
    logic [7:0]    sub_cpu_din;
    logic          sub_wait_n;
    logic          comm_cs;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [AW-1:0] main_addr;
    logic          main_we;

    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;

    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic [7:0] last_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtexterm_sub_comm #(.AW(AW), .BASE(16'hC000), .MAXWAIT(MAXWAIT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snd_rstn     (snd_rstn),
        .sub_A        (sub_A),
        .sub_mreq_n   (sub_mreq_n),
        .sub_rd_n     (sub_rd_n),
        .sub_wr_n     (sub_wr_n),
        .sub_cpu_dout (sub_cpu_dout),
        .sub_cpu_din  (sub_cpu_din),
        .sub_wait_n   (sub_wait_n),
        .comm_cs      (comm_cs),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .main_addr    (main_addr),
        .main_we      (main_we)
    );

    // Port-1 RAM stub: registered read, data valid one clk after the address.
    always @(posedge clk) begin
        ram_din <= mem[ram_addr];
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_dout;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete sub CPU cycle; k = clocks of main write activity from strobe onset.
    task automatic access(input string tag, input logic [15:0] a, input bit wr,
                          input logic [7:0] d, input int k, input bit match);
        int   lows, we_cnt, we_addr, we_data, stall, exp_lows;
        bit   inwin;
        inwin   = (a[15:13] == 3'b110);
        lows    = 0;
        we_cnt  = 0;
        we_addr = 0;
        we_data = 0;
        @(negedge clk);
        sub_A        = a;
        sub_mreq_n   = 1'b0;
        sub_rd_n     = wr;
        sub_wr_n     = !wr;
        sub_cpu_dout = d;
        main_addr    = match ? a[AW-1:0] : (a[AW-1:0] ^ 13'h0155);
        for (int c = 0; c < 30; c++) begin
            main_we = (c < k);
            #1;
            if (c == 0) check({tag, ".cs"}, comm_cs, inwin);
            if (ram_we) begin
                we_cnt++;
                we_addr = ram_addr;
                we_data = ram_dout;
            end
            if (sub_wait_n) break;
            lows++;
            @(negedge clk);
        end
        @(negedge clk);
        main_we = 1'b0;
        #1;
        if (ram_we) we_cnt++;
        check({tag, ".hold"}, sub_wait_n, 1);
        @(negedge clk);
        sub_mreq_n = 1'b1;
        sub_rd_n   = 1'b1;
        sub_wr_n   = 1'b1;
        #1;
        if (ram_we) we_cnt++;
        @(negedge clk);
        #1;
        if (ram_we) we_cnt++;

        if (!inwin) begin
            check({tag, ".wait"}, lows, 0);
            check({tag, ".we"}, we_cnt, 0);
            check({tag, ".din"}, sub_cpu_din, last_rd);
        end else begin
            stall    = match ? ((k < MAXWAIT) ? k : MAXWAIT) : 0;
            exp_lows = (wr ? 2 : 3) + stall;
            check({tag, ".wait"}, lows, exp_lows);
            if (wr) begin
                check({tag, ".we"}, we_cnt, 1);
                check({tag, ".waddr"}, we_addr, a[AW-1:0]);
                check({tag, ".wdata"}, we_data, d);
                ref_mem[a[AW-1:0]] = d;
                check({tag, ".din"}, sub_cpu_din, last_rd);
            end else begin
                check({tag, ".we"}, we_cnt, 0);
                last_rd = ref_mem[a[AW-1:0]];
                check({tag, ".din"}, sub_cpu_din, last_rd);
            end
        end
    endtask

    initial begin
        logic [15:0] a;
        rst_n        = 1'b0;
        snd_rstn     = 1'b1;
        sub_A        = 16'h0000;
        sub_mreq_n   = 1'b1;
        sub_rd_n     = 1'b1;
        sub_wr_n     = 1'b1;
        sub_cpu_dout = 8'h00;
        main_addr    = '0;
        main_we      = 1'b0;
        ld_we        = 1'b0;
        ld_addr      = '0;
        ld_data      = 8'h00;
        last_rd      = 8'hFF;

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 8'($urandom);
        ref_mem[13'h0010] = 8'h3C;
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = ref_mem[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
        #1;
        check("rst.we", ram_we, 0);
        check("rst.wait", sub_wait_n, 1);
        check("rst.din", sub_cpu_din, 8'hFF);
        check("rst.addr", ram_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst.cs", comm_cs, 0);
        check("rst.wait2", sub_wait_n, 1);

        access("wr_c123", 16'hC123, 1'b1, 8'h5A, 0, 1'b1);
        access("rd_c010", 16'hC010, 1'b0, 8'h00, 0, 1'b1);
        access("rd_stall2", 16'hC010, 1'b0, 8'h00, 2, 1'b1);
        access("rd_force", 16'hC010, 1'b0, 8'h00, 1000, 1'b1);
        access("wr_force", 16'hC055, 1'b1, 8'hA7, 1000, 1'b1);
        access("rd_nomatch", 16'hC010, 1'b0, 8'h00, 5, 1'b0);
        access("rd_8000", 16'h8000, 1'b0, 8'h00, 0, 1'b1);
        access("wr_8000", 16'h8000, 1'b1, 8'h11, 0, 1'b1);

        // Block reset while the access is stalled by a main write.
        @(negedge clk);
        sub_A      = 16'hC200;
        sub_mreq_n = 1'b0;
        sub_rd_n   = 1'b0;
        main_addr  = 13'h0200;
        main_we    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        snd_rstn = 1'b0;
        @(negedge clk);
        #1;
        check("srst.wait", sub_wait_n, 0);
        check("srst.we", ram_we, 0);
        check("srst.din", sub_cpu_din, 8'hFF);
        check("srst.addr", ram_addr, 0);
        last_rd    = 8'hFF;
        sub_mreq_n = 1'b1;
        sub_rd_n   = 1'b1;
        main_we    = 1'b0;
        #1;
        check("srst.wait_idle", sub_wait_n, 1);
        @(negedge clk);
        snd_rstn = 1'b1;
        access("wr_after_srst", 16'hC200, 1'b1, 8'hC3, 0, 1'b1);
        access("rd_after_srst", 16'hC200, 1'b0, 8'h00, 1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0)
                a = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'hBFFF))
                                                : 16'($urandom_range(16'hE000, 16'hFFFF));
            else
                a = {3'b110, 13'($urandom)};
            access("rnd", a, 1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom_range(0, 6), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
